mmu_arbiter: RTL and testbench
==============================

MMU_ARBITER -- requirements
Module: mmu_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive cycles m0 waits while m1 holds the lock.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports m0_req, m1_req  input  1 each  access request.
REQ-005 SHALL have ports m0_addr, m1_addr  input  32 each  byte address.
REQ-006 SHALL have ports m0_wdata, m1_wdata  input  32 each  store data, right-justified.
REQ-007 SHALL have ports m0_be, m1_be  input  4 each  non-encoded byte enable.
REQ-008 SHALL have ports m0_we, m1_we, m0_signed, m1_signed  input  1 each  write enable and sign-extend select.
REQ-009 SHALL have port m1_lock  input  1  m1 requests back-to-back ownership.
REQ-010 SHALL have ports m0_gnt, m1_gnt  output  1 each  request accepted this cycle.
REQ-011 SHALL have ports m0_rvalid, m1_rvalid, m0_err, m1_err  output  1 each  read-data valid and access error.
REQ-012 SHALL have port rdata  output  32  read data shared by both masters.
REQ-013 SHALL have ports dm_addr (32), dm_di (32), dm_be (4), dm_we (1), is_signed (1)  output  MMU data-port drive.
REQ-014 SHALL have port dm_do  input  32  MMU load data, valid one cycle after issue.

Function
REQ-015 SHALL assert at most one gnt per cycle; a gnt is combinational in the request cycle and the granted fields drive dm_* in that same cycle.
REQ-016 SHALL drive dm_be=0000, dm_we=0, dm_addr=0, dm_di=0 and is_signed=0 in any cycle with no grant or with a suppressed grant.
REQ-017 SHALL arbitrate round-robin in state IDLE: a sole requester wins; if both request, the master not recorded in last_winner wins; last_winner updates on every grant.
REQ-018 SHALL move from IDLE to LOCKED when m1 is granted with m1_lock=1.
REQ-019 SHALL, in LOCKED, grant m1 whenever m1_req=1 regardless of m0_req.
REQ-020 SHALL leave LOCKED for IDLE on a granted m1 beat with m1_lock=0, on any cycle with m1_req=0, or on starvation.
REQ-021 SHALL count consecutive LOCKED cycles in which m0_req=1 and m0 is not granted; the counter saturates and clears whenever m0 is granted or the state is IDLE.
REQ-022 SHALL, when the counter equals STARVE_LIMIT, grant m0 that cycle, enter IDLE and set last_winner=m0, overriding any lock request made in the same cycle.
REQ-023 SHALL treat an access as illegal if be is not one of 1111, 1100, 0011, 0001, 0010, 0100 or 1000.
REQ-024 SHALL treat an access as illegal if the address falls outside 0x00000000-0x00000FFF, 0x10000000-0x7FFFFFFF and 0x80000000-0x800000FF.
REQ-025 SHALL treat an access as illegal if we=1 with an address in 0x00000000-0x00000FFF (ROM).
REQ-026 SHALL still grant an illegal access, suppress it per REQ-016, and pulse the owner's err for one cycle, in the cycle after the grant.
REQ-027 SHALL register the owner, read flag and error flag at each grant, and assert the owner's rvalid for exactly one cycle, in the cycle after a legal read grant, with rdata=dm_do.
REQ-028 SHALL give writes no rvalid: gnt is their completion.
REQ-029 SHALL drive rdata=0 whenever no rvalid is asserted.
REQ-030 SHALL sustain one access per cycle with no bubbles, including on owner switches.

Reset
REQ-031 SHALL, while reset=1, force state IDLE, last_winner=m1 (so m0 wins first), starvation counter 0 and registered response fields cleared.
REQ-032 SHALL hold all gnt, rvalid and err outputs at 0 and dm_* per REQ-016 while reset=1.
REQ-033 SHALL, on reset asserted mid-operation, drop any pending response, so no rvalid or err appears in the cycle after reset deasserts.

Structure
REQ-034 SHALL take region base/limit constants, the legal-BE set and master-ID constants (M0=0, M1=1) from shared package mmu_pkg.
REQ-035 SHALL define the arbiter state enum (IDLE, LOCKED) in mmu_pkg.
REQ-036 SHALL place the legality checks of REQ-023 to REQ-025 in one combinational sub-module, mmu_access_check, instantiated once on the muxed request.

Verification
REQ-037 SHALL check: both masters request reads every cycle from reset -> gnt order m0,m1,m0,m1; each rvalid appears one cycle after its gnt with the matching dm_do.
REQ-038 SHALL check: m1 holds m1_lock=1 and m1_req=1 while m0_req=1 continuously, STARVE_LIMIT=4 -> m1 gets 5 grants, m0 is granted on cycle 6, then alternation resumes.
REQ-039 SHALL check: m0 write with be=0110 to 0x10000004 -> gnt=1, dm_be=0000, dm_we=0, m0_err pulses one cycle later, no rvalid.
REQ-040 SHALL check: m1 write to 0x00000010 and m1 read of 0x90000000 -> both suppressed, m1_err pulses after each, no rvalid.
REQ-041 SHALL check: reset asserted in the cycle of an m0 read grant -> no m0_rvalid afterwards; the first grant after reset goes to m0.
REQ-042 SHALL check: m1 granted with m1_lock=1, then m1_req drops while m0_req=1 -> m0 granted in that same cycle and state returns to IDLE.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared definitions for the MMU data-port arbiter: master IDs, arbiter states,
// address map and the legal byte-enable set.
package mmu_pkg;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
    localparam logic [31:0] ROM_LIMIT = 32'h0000_0FFF;
    localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
    localparam logic [31:0] RAM_LIMIT = 32'h7FFF_FFFF;
    localparam logic [31:0] IO_BASE   = 32'h8000_0000;
    localparam logic [31:0] IO_LIMIT  = 32'h8000_00FF;

    localparam int NUM_LEGAL_BE = 7;
    localparam logic [3:0] LEGAL_BE [NUM_LEGAL_BE] = '{
        4'b1111, 4'b1100, 4'b0011, 4'b0001, 4'b0010, 4'b0100, 4'b1000
    };

    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

    function automatic logic be_legal(input logic [3:0] be);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_LEGAL_BE; i++) begin
            if (be == LEGAL_BE[i]) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/mmu_access_check.sv
// Combinational legality check of one access: byte-enable shape, address map
// and writes into ROM.
module mmu_access_check
    import mmu_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic        we,
    output logic        illegal
);

    logic in_rom;
    logic in_ram;
    logic in_io;

    assign in_rom = in_region(addr, ROM_BASE, ROM_LIMIT);
    assign in_ram = in_region(addr, RAM_BASE, RAM_LIMIT);
    assign in_io  = in_region(addr, IO_BASE, IO_LIMIT);

    assign illegal = !be_legal(be) || !(in_rom || in_ram || in_io) || (we && in_rom);

endmodule

// File: rtl/mmu_arbiter.sv
// Two-master arbiter for the MMU data port: round-robin with an m1 lock mode,
// starvation relief for m0, illegal-access suppression and one-cycle read return.
module mmu_arbiter
    import mmu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m0_be,
    input  logic [3:0]  m1_be,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic        m0_signed,
    input  logic        m1_signed,
    input  logic        m1_lock,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_di,
    output logic [3:0]  dm_be,
    output logic        dm_we,
    output logic        is_signed,
    input  logic [31:0] dm_do
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_e           state_q, state_d;
    master_e          last_q, last_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             rsp_rd_q, rsp_rd_d;
    logic             rsp_err_q, rsp_err_d;
    master_e          rsp_owner_q, rsp_owner_d;

    logic        grant;
    logic        starve;
    master_e     winner;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic        sel_we;
    logic        sel_signed;
    logic        illegal;
    logic        issue;

    assign starve = (state_q == LOCKED) && m0_req && (starve_q == CNT_MAX);

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        grant  = 1'b0;
        winner = M0;
        if (!reset) begin
            if (state_q == LOCKED) begin
                if (starve) begin
                    grant  = 1'b1;
                    winner = M0;
                end else if (m1_req) begin
                    grant  = 1'b1;
                    winner = M1;
                end else if (m0_req) begin
                    grant  = 1'b1;
                    winner = M0;
                end
            end else if (m0_req && m1_req) begin
                grant  = 1'b1;
                winner = (last_q == M0) ? M1 : M0;
            end else if (m0_req || m1_req) begin
                grant  = 1'b1;
                winner = m1_req ? M1 : M0;
            end
        end
    end

    assign sel_addr   = (winner == M1) ? m1_addr   : m0_addr;
    assign sel_wdata  = (winner == M1) ? m1_wdata  : m0_wdata;
    assign sel_be     = (winner == M1) ? m1_be     : m0_be;
    assign sel_we     = (winner == M1) ? m1_we     : m0_we;
    assign sel_signed = (winner == M1) ? m1_signed : m0_signed;

    mmu_access_check u_access_check (
        .addr    (sel_addr),
        .be      (sel_be),
        .we      (sel_we),
        .illegal (illegal)
    );

    // Illegal accesses are still granted but never reach the data port.
    assign issue     = grant && !illegal;
    assign m0_gnt    = grant && (winner == M0);
    assign m1_gnt    = grant && (winner == M1);
    assign dm_addr   = issue ? sel_addr   : '0;
    assign dm_di     = issue ? sel_wdata  : '0;
    assign dm_be     = issue ? sel_be     : '0;
    assign dm_we     = issue ? sel_we     : 1'b0;
    assign is_signed = issue ? sel_signed : 1'b0;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        starve_d    = '0;
        rsp_rd_d    = grant && !sel_we;
        rsp_err_d   = grant && illegal;
        rsp_owner_d = winner;
        if (grant) last_d = winner;
        case (state_q)
            IDLE: begin
                if (m1_gnt && m1_lock) state_d = LOCKED;
            end
            LOCKED: begin
                if (!(m1_gnt && m1_lock)) state_d = IDLE;
                if (m0_req && !m0_gnt) begin
                    starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= M1;
            starve_q    <= '0;
            rsp_rd_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_owner_q <= M0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            starve_q    <= starve_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    assign m0_rvalid = !reset && rsp_rd_q && !rsp_err_q && (rsp_owner_q == M0);
    assign m1_rvalid = !reset && rsp_rd_q && !rsp_err_q && (rsp_owner_q == M1);
    assign m0_err    = !reset && rsp_err_q && (rsp_owner_q == M0);
    assign m1_err    = !reset && rsp_err_q && (rsp_owner_q == M1);
    assign rdata     = (m0_rvalid || m1_rvalid) ? dm_do : '0;

endmodule

// File: tb/tb_mmu_arbiter.sv
// Scoreboard bench for mmu_arbiter: a reference model predicts grants and data-port
// drive each cycle and queues the expected response for the following cycle.
module tb_mmu_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_we, m1_we, m0_signed, m1_signed, m1_lock;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] rdata, dm_addr, dm_di, dm_do;
    logic [3:0]  dm_be;
    logic        dm_we, is_signed;

    always #5 clk = ~clk;

    mmu_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m1_req    (m1_req),
        .m0_addr   (m0_addr),
        .m1_addr   (m1_addr),
        .m0_wdata  (m0_wdata),
        .m1_wdata  (m1_wdata),
        .m0_be     (m0_be),
        .m1_be     (m1_be),
        .m0_we     (m0_we),
        .m1_we     (m1_we),
        .m0_signed (m0_signed),
        .m1_signed (m1_signed),
        .m1_lock   (m1_lock),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_rvalid (m1_rvalid),
        .m0_err    (m0_err),
        .m1_err    (m1_err),
        .rdata     (rdata),
        .dm_addr   (dm_addr),
        .dm_di     (dm_di),
        .dm_be     (dm_be),
        .dm_we     (dm_we),
        .is_signed (is_signed),
        .dm_do     (dm_do)
    );

    typedef struct {
        logic rv0;
        logic rv1;
        logic e0;
        logic e1;
    } rsp_t;

    rsp_t rsp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model state: lock mode, who won last (1 = m1), cycles m0 has waited.
    logic md_locked;
    logic md_last;
    int   md_wait;

    // Observations of the most recent cycle, used by scenario-specific checks.
    logic [1:0] obs_g;
    logic [3:0] obs_be;
    logic       obs_rv0, obs_e0, obs_e1;

    logic [31:0] addr_tab [10] = '{
        32'h0000_0010, 32'h0000_0FFC, 32'h1000_0000, 32'h7FFF_FFFC, 32'h8000_0000,
        32'h8000_00FC, 32'h8000_0100, 32'h9000_0000, 32'h0000_1000, 32'h0FFF_FFFC
    };
    logic [3:0] be_tab [10] = '{
        4'b1111, 4'b1100, 4'b0011, 4'b0001, 4'b0010,
        4'b0100, 4'b1000, 4'b0110, 4'b0000, 4'b1110
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ref_illegal(input logic [31:0] a, input logic [3:0] be,
                                         input logic we);
        logic be_ok, in_rom, in_ram, in_io;
        be_ok  = be inside {4'b1111, 4'b1100, 4'b0011, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        in_rom = a < 32'h0000_1000;
        in_ram = (a >= 32'h1000_0000) && (a < 32'h8000_0000);
        in_io  = (a >= 32'h8000_0000) && (a < 32'h8000_0100);
        return !be_ok || !(in_rom || in_ram || in_io) || (we && in_rom);
    endfunction

    task automatic idle_inputs();
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        m0_we = 1'b0; m1_we = 1'b0; m0_signed = 1'b0; m1_signed = 1'b0;
        m0_be = 4'b1111; m1_be = 4'b1111;
        m0_addr = 32'h1000_0000; m1_addr = 32'h8000_0000;
        m0_wdata = '0; m1_wdata = '0;
    endtask

    // Called just after a rising edge with inputs already set; checks this cycle
    // and advances the model across the next edge.
    task automatic cycle();
        logic [1:0]  gexp;
        logic        ill, use1, w_we;
        logic [31:0] w_addr;
        logic [3:0]  w_be;
        rsp_t        exp_rsp, new_rsp;
        dm_do = $urandom;
        #3;
        gexp = 2'b00;
        if (!reset) begin
            if (md_locked) begin
                if (m0_req && md_wait == STARVE_LIMIT) gexp = 2'b01;
                else if (m1_req)                       gexp = 2'b10;
                else if (m0_req)                       gexp = 2'b01;
            end else if (m0_req && m1_req) begin
                gexp = md_last ? 2'b01 : 2'b10;
            end else begin
                gexp = {m1_req, m0_req};
            end
        end
        use1   = gexp[1];
        w_addr = use1 ? m1_addr : m0_addr;
        w_be   = use1 ? m1_be   : m0_be;
        w_we   = use1 ? m1_we   : m0_we;
        ill    = ref_illegal(w_addr, w_be, w_we);

        obs_g  = {m1_gnt, m0_gnt};
        obs_be = dm_be;
        obs_rv0 = m0_rvalid; obs_e0 = m0_err; obs_e1 = m1_err;

        check("m0_gnt", m0_gnt, gexp[0]);
        check("m1_gnt", m1_gnt, gexp[1]);
        if (gexp != 2'b00 && !ill) begin
            check("dm_addr", dm_addr, w_addr);
            check("dm_di", dm_di, use1 ? m1_wdata : m0_wdata);
            check("dm_be", dm_be, w_be);
            check("dm_we", dm_we, w_we);
            check("is_signed", is_signed, use1 ? m1_signed : m0_signed);
        end else begin
            check("dm_idle", {dm_addr ^ dm_di, 28'd0}, '0);
            check("dm_idle_addr", dm_addr, '0);
            check("dm_idle_ctl", {dm_be, dm_we, is_signed}, '0);
        end

        exp_rsp = '{rv0: 1'b0, rv1: 1'b0, e0: 1'b0, e1: 1'b0};
        if (rsp_q.size() > 0) exp_rsp = rsp_q.pop_front();
        if (reset) exp_rsp = '{rv0: 1'b0, rv1: 1'b0, e0: 1'b0, e1: 1'b0};
        check("m0_rvalid", m0_rvalid, exp_rsp.rv0);
        check("m1_rvalid", m1_rvalid, exp_rsp.rv1);
        check("m0_err", m0_err, exp_rsp.e0);
        check("m1_err", m1_err, exp_rsp.e1);
        check("rdata", rdata, (exp_rsp.rv0 || exp_rsp.rv1) ? dm_do : 32'd0);

        new_rsp = '{rv0: gexp[0] && !w_we && !ill, rv1: gexp[1] && !w_we && !ill,
                    e0: gexp[0] && ill, e1: gexp[1] && ill};
        if (reset) begin
            md_locked = 1'b0;
            md_last   = 1'b1;
            md_wait   = 0;
            rsp_q.delete();
            new_rsp = '{rv0: 1'b0, rv1: 1'b0, e0: 1'b0, e1: 1'b0};
        end else begin
            if (gexp[0]) md_last = 1'b0;
            if (gexp[1]) md_last = 1'b1;
            if (md_locked && gexp[1]) begin
                md_locked = m1_lock;
                md_wait   = m0_req ? md_wait + 1 : 0;
            end else begin
                md_locked = !md_locked && gexp[1] && m1_lock;
                md_wait   = 0;
            end
        end
        rsp_q.push_back(new_rsp);
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rr_pat   [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    logic [1:0] lock_pat [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01};

    initial begin
        idle_inputs();
        reset = 1'b1;
        dm_do = '0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        reset = 1'b0;

        // Both masters read every cycle: strict alternation starting with m0.
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            m0_addr = 32'h1000_0000 + 32'(i * 4);
            m1_addr = 32'h8000_0010 + 32'(i * 4);
            cycle();
            check("rr_order", obs_g, rr_pat[i]);
        end

        // m1 holds the lock while m0 keeps asking: relief after STARVE_LIMIT waits.
        m1_lock = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i >= 5) m1_lock = 1'b0;
            cycle();
            check("lock_order", obs_g, lock_pat[i]);
        end
        idle_inputs();
        cycle();

        // m0 write with an unsupported byte-enable shape.
        m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'b0110; m0_addr = 32'h1000_0004;
        m0_wdata = 32'hDEAD_BEEF;
        cycle();
        check("bad_be_gnt", obs_g, 2'b01);
        check("bad_be_dm_be", obs_be, 4'b0000);
        idle_inputs();
        cycle();
        check("bad_be_err", obs_e0, 1'b1);
        check("bad_be_no_rv", obs_rv0, 1'b0);

        // m1 write into ROM, then m1 read of an unmapped address.
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0010;
        cycle();
        m1_we = 1'b0; m1_addr = 32'h9000_0000;
        cycle();
        check("rom_wr_err", obs_e1, 1'b1);
        idle_inputs();
        cycle();
        check("unmapped_err", obs_e1, 1'b1);

        // Reset lands while an m0 read response is pending.
        m0_req = 1'b1;
        cycle();
        reset = 1'b1;
        cycle();
        check("rst_no_rv", obs_rv0, 1'b0);
        reset = 1'b0;
        m1_req = 1'b1;
        cycle();
        check("post_rst_no_rv", obs_rv0, 1'b0);
        check("post_rst_first", obs_g, 2'b01);
        idle_inputs();
        cycle();

        // Locked m1 drops its request while m0 waits: m0 wins in that cycle.
        m1_req = 1'b1; m1_lock = 1'b1;
        cycle();
        m1_req = 1'b0; m0_req = 1'b1;
        cycle();
        check("unlock_m0", obs_g, 2'b01);
        idle_inputs();
        cycle();

        // Random traffic across boundary addresses, odd byte enables and locks.
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 59) == 0);
            m0_req    = ($urandom_range(0, 3) != 0);
            m1_req    = ($urandom_range(0, 3) != 0);
            m1_lock   = ($urandom_range(0, 2) != 0);
            m0_we     = $urandom_range(0, 1);
            m1_we     = $urandom_range(0, 1);
            m0_signed = $urandom_range(0, 1);
            m1_signed = $urandom_range(0, 1);
            m0_addr   = addr_tab[$urandom_range(0, 9)];
            m1_addr   = addr_tab[$urandom_range(0, 9)];
            m0_be     = be_tab[$urandom_range(0, 9)];
            m1_be     = be_tab[$urandom_range(0, 9)];
            m0_wdata  = $urandom;
            m1_wdata  = $urandom;
            cycle();
        end
        reset = 1'b0;
        idle_inputs();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
